// File: rtl/dispatch_lane_cfg_ctrl_pkg.sv
// Shared lane-mask type, controller state encoding and mask legalisation for dispatch_lane_cfg_ctrl.
// Latency: none (types and a pure function only).
// Backpressure: none.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

package dispatch_cfg_pkg;

    localparam int DISPATCH_WIDTH = `DISPATCH_WIDTH;

    typedef logic [`DISPATCH_WIDTH-1:0] laneMask_t;

    // Explicit 3-bit encoding so the state register matches older netlists bit for bit.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        RESUME = 3'd4
    } laneCfgState_t;

    // Lane 0 is never gated, and the active set must be contiguous from lane 0,
    // so keep the run of ones starting at bit 0 and drop everything after the first zero.
    function automatic laneMask_t legalizeMask(input laneMask_t req);
        laneMask_t m;
        m    = '0;
        m[0] = 1'b1;
        for (int i = 1; i < DISPATCH_WIDTH; i++) begin
            m[i] = m[i-1] & req[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/dispatch_lane_cfg_ctrl_lane_settle_timer.sv
// 8-bit loadable down-counter with a zero flag; times both the drain timeout and the lane settle.
// Latency: load takes effect the cycle after load_i; done_o is a decode of the count register.
// Backpressure: none; decrement stops at zero and the count holds until reloaded.
module lane_settle_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [7:0] cnt_q;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 8'd0)) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/dispatch_lane_cfg_ctrl.sv
// Sequences lane-mask changes for InstBuf->Rename: drain, hold the buffer, apply mask, settle, resume.
// Latency: cfgReq_i to cfgAck_o is drain + SETTLE_CYCLES + 2 cycles (SETTLE_CYCLES+3 with an empty pipe).
// Backpressure: holds instruction-buffer read-out and adds a stall term while busy; optional perf
// counters are built when LANE_CFG_PERF_EN is defined.
module dispatch_lane_cfg_ctrl
    import dispatch_cfg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      cfgReq_i,
    input  laneMask_t cfgLaneMask_i,
    input  logic      flush_i,
    input  logic      renStall_i,
    input  logic      pipeEmpty_i,
    output laneMask_t laneActive_o,
    output logic      holdInstBuf_o,
    output logic      stall_o,
    output logic      forceFlush_o,
    output logic      cfgAck_o,
    output logic      cfgBusy_o
`ifdef LANE_CFG_PERF_EN
    ,
    output logic [15:0] cfgCount_o,
    output logic [31:0] holdCycles_o
`endif
);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end
    if ((DRAIN_TIMEOUT < 1) || (DRAIN_TIMEOUT > 255)) begin : g_bad_drain
        $error("DRAIN_TIMEOUT must be in 1..255");
    end

    laneCfgState_t state_q;
    laneMask_t     lane_active_q;
    laneMask_t     pend_mask_q;
    logic          hold_q;
    logic          stall_hold_q;
    logic          force_flush_q;
    logic          cfg_ack_q;
    logic          timed_out_q;
    logic          drain_exit;
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_done;
    logic [7:0]    tmr_load_val;

    // A flush empties the InstBuf->Rename register as far as we care, regardless of stall.
    assign drain_exit = flush_i | (pipeEmpty_i & ~renStall_i);

    // One timer serves both phases: drain timeout is armed on leaving IDLE, settle on GATE.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_load_val = 8'(DRAIN_TIMEOUT - 1);
        case (state_q)
            IDLE:    tmr_load = cfgReq_i;
            DRAIN:   tmr_dec  = 1'b1;
            GATE: begin
                tmr_load     = 1'b1;
                tmr_load_val = 8'(SETTLE_CYCLES - 1);
            end
            SETTLE:  tmr_dec  = 1'b1;
            default: tmr_dec  = 1'b0;
        endcase
    end

    lane_settle_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .done_o     (tmr_done)
    );

    // Configuration sequence; every output is a register updated on the state transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            lane_active_q <= '1;
            pend_mask_q   <= '1;
            hold_q        <= 1'b0;
            stall_hold_q  <= 1'b0;
            force_flush_q <= 1'b0;
            cfg_ack_q     <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            force_flush_q <= 1'b0;
            cfg_ack_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfgReq_i) begin
                        pend_mask_q <= legalizeMask(cfgLaneMask_i);
                        hold_q      <= 1'b1;
                        timed_out_q <= 1'b0;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state_q <= GATE;
                    end else if (tmr_done && !timed_out_q) begin
                        // Single flush request per drain; keep waiting for the pipe to empty.
                        force_flush_q <= 1'b1;
                        timed_out_q   <= 1'b1;
                    end
                end
                GATE: begin
                    lane_active_q <= pend_mask_q;
                    stall_hold_q  <= 1'b1;
                    state_q       <= SETTLE;
                end
                SETTLE: begin
                    if (tmr_done) begin
                        hold_q       <= 1'b0;
                        stall_hold_q <= 1'b0;
                        cfg_ack_q    <= 1'b1;
                        state_q      <= RESUME;
                    end
                end
                RESUME:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign laneActive_o  = lane_active_q;
    assign holdInstBuf_o = hold_q;
    assign stall_o       = renStall_i | stall_hold_q;
    assign forceFlush_o  = force_flush_q;
    assign cfgAck_o      = cfg_ack_q;
    assign cfgBusy_o     = (state_q != IDLE);

`ifdef LANE_CFG_PERF_EN
    logic [15:0] cfg_count_q;
    logic [31:0] hold_cycles_q;

    // Saturating event counters: completed reconfigurations and cycles spent holding the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_count_q   <= 16'd0;
            hold_cycles_q <= 32'd0;
        end else begin
            if (cfg_ack_q && (cfg_count_q != 16'hFFFF)) begin
                cfg_count_q <= cfg_count_q + 16'd1;
            end
            if (hold_q && (hold_cycles_q != 32'hFFFF_FFFF)) begin
                hold_cycles_q <= hold_cycles_q + 32'd1;
            end
        end
    end

    assign cfgCount_o   = cfg_count_q;
    assign holdCycles_o = hold_cycles_q;
`endif

endmodule

// File: tb/tb_dispatch_lane_cfg_ctrl.sv
// Self-checking bench for dispatch_lane_cfg_ctrl: directed sequences, a vector table and a random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_dispatch_lane_cfg_ctrl;

    localparam int ST = 8;
    localparam int DT = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfgReq_i = 1'b0;
    logic [3:0] cfgLaneMask_i = 4'b0000;
    logic       flush_i = 1'b0;
    logic       renStall_i = 1'b0;
    logic       pipeEmpty_i = 1'b0;
    logic [3:0] laneActive_o;
    logic       holdInstBuf_o;
    logic       stall_o;
    logic       forceFlush_o;
    logic       cfgAck_o;
    logic       cfgBusy_o;
`ifdef LANE_CFG_PERF_EN
    logic [15:0] cfgCount_o;
    logic [31:0] holdCycles_o;
`endif

    int checks = 0;
    int errors = 0;

    dispatch_lane_cfg_ctrl #(.SETTLE_CYCLES(ST), .DRAIN_TIMEOUT(DT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfgReq_i      (cfgReq_i),
        .cfgLaneMask_i (cfgLaneMask_i),
        .flush_i       (flush_i),
        .renStall_i    (renStall_i),
        .pipeEmpty_i   (pipeEmpty_i),
        .laneActive_o  (laneActive_o),
        .holdInstBuf_o (holdInstBuf_o),
        .stall_o       (stall_o),
        .forceFlush_o  (forceFlush_o),
        .cfgAck_o      (cfgAck_o),
        .cfgBusy_o     (cfgBusy_o)
`ifdef LANE_CFG_PERF_EN
        ,
        .cfgCount_o    (cfgCount_o),
        .holdCycles_o  (holdCycles_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        int         busy_n;
        bit         use_flush;
        logic [3:0] exp_lane;
        int         exp_ack;
    } vec_t;

    vec_t vec [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference legalisation: length of the run of ones from bit 0 (bit 0 forced on).
    function automatic logic [3:0] legal_ref(input logic [3:0] m);
        logic [3:0] mm;
        int n;
        mm = m | 4'b0001;
        n  = 0;
        while (n < 4 && mm[n]) n++;
        return 4'((1 << n) - 1);
    endfunction

    // Behavioural model state: a request is described by its start cycle, drain exit cycle and mask.
    bit         m_act;
    int         m_s;
    int         m_e;
    logic [3:0] m_pend;
    logic [3:0] m_cur;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{4'b0011, 0, 1'b0, 4'b0011, 11};
        vec[1] = '{4'b1101, 0, 1'b0, 4'b0001, 11};
        vec[2] = '{4'b0000, 3, 1'b0, 4'b0001, 14};
        vec[3] = '{4'b0110, 2, 1'b1, 4'b0111, 13};
        vec[4] = '{4'b1111, 5, 1'b0, 4'b1111, 16};
        vec[5] = '{4'b1011, 0, 1'b1, 4'b0011, 11};

        // Reset state
        #12;
        chk("rst_lane", laneActive_o, 4'b1111);
        chk("rst_hold", holdInstBuf_o, 1'b0);
        chk("rst_busy", cfgBusy_o, 1'b0);
        chk("rst_ack", cfgAck_o, 1'b0);
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_lane", laneActive_o, 4'b1111);
        chk("idle_stall", stall_o, 1'b0);
        chk("idle_ff", forceFlush_o, 1'b0);
        tick();

        // Minimum-latency request with an empty pipe
        cfgReq_i = 1'b1; cfgLaneMask_i = 4'b0011; pipeEmpty_i = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 12) cfgReq_i = 1'b0;
            @(negedge clk);
            if (c == 2) chk("min_lane_c2", laneActive_o, 4'b1111);
            if (c == 3) chk("min_lane_c3", laneActive_o, 4'b0011);
            chk("min_ack", cfgAck_o, (c == 11));
            chk("min_hold", holdInstBuf_o, (c >= 1 && c <= 10));
            chk("min_stall", stall_o, (c >= 3 && c <= 10));
            chk("min_busy", cfgBusy_o, (c >= 1 && c <= 11));
            tick();
        end

        // Drain timeout: pipe stays full, one forced flush at drain cycle 64
        cfgReq_i = 1'b1; cfgLaneMask_i = 4'b0111; pipeEmpty_i = 1'b0;
        for (int c = 0; c <= 90; c++) begin
            if (c == 1) cfgReq_i = 1'b0;
            if (c == 71) pipeEmpty_i = 1'b1;
            @(negedge clk);
            chk("to_ff", forceFlush_o, (c == 65));
            if (c == 72) chk("to_lane_c72", laneActive_o, 4'b0011);
            if (c == 73) chk("to_lane_c73", laneActive_o, 4'b0111);
            chk("to_ack", cfgAck_o, (c == 81));
            tick();
        end

        // Flush in DRAIN exits; mask changes and flushes after GATE are ignored
        cfgReq_i = 1'b1; cfgLaneMask_i = 4'b1111; pipeEmpty_i = 1'b0; renStall_i = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            flush_i = (c == 2) || (c == 7) || (c == 8);
            if (c == 5) cfgLaneMask_i = 4'b0001;
            if (c == 13) cfgReq_i = 1'b0;
            @(negedge clk);
            if (c == 3) chk("fl_lane_c3", laneActive_o, 4'b0111);
            if (c == 4) chk("fl_lane_c4", laneActive_o, 4'b1111);
            if (c == 14) chk("fl_lane_end", laneActive_o, 4'b1111);
            chk("fl_ack", cfgAck_o, (c == 12));
            tick();
        end
        flush_i = 1'b0; renStall_i = 1'b0;

        // Vector table
        for (int v = 0; v < 6; v++) begin
            int ack_at;
            ack_at = -1;
            cfgReq_i = 1'b1; cfgLaneMask_i = vec[v].mask;
            for (int c = 0; c < 200 && ack_at < 0; c++) begin
                pipeEmpty_i = !vec[v].use_flush && (c > vec[v].busy_n);
                flush_i     = vec[v].use_flush && (c == vec[v].busy_n + 1);
                @(negedge clk);
                if (cfgAck_o) begin
                    ack_at = c;
                    chk("vec_lane", laneActive_o, vec[v].exp_lane);
                end
                tick();
            end
            chk("vec_ack_cycle", ack_at, vec[v].exp_ack);
            cfgReq_i = 1'b0; flush_i = 1'b0;
            @(negedge clk);
            chk("vec_idle_busy", cfgBusy_o, 1'b0);
            tick();
        end

        // Asynchronous reset in the middle of SETTLE
        cfgReq_i = 1'b1; cfgLaneMask_i = 4'b0001; pipeEmpty_i = 1'b1;
        tick();
        cfgReq_i = 1'b0;
        repeat (4) tick();
        chk("ar_pre_lane", laneActive_o, 4'b0001);
        chk("ar_pre_busy", cfgBusy_o, 1'b1);
        renStall_i = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_lane", laneActive_o, 4'b1111);
        chk("ar_hold", holdInstBuf_o, 1'b0);
        chk("ar_stall_hi", stall_o, 1'b1);
        chk("ar_ff", forceFlush_o, 1'b0);
        chk("ar_ack", cfgAck_o, 1'b0);
        chk("ar_busy", cfgBusy_o, 1'b0);
        renStall_i = 1'b0;
        #1;
        chk("ar_stall_lo", stall_o, 1'b0);
        #3;
        reset_n = 1'b1;
        tick();

        // Random run against the transaction-level model
        m_act = 1'b0; m_s = 0; m_e = -1; m_pend = 4'hF; m_cur = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            logic r_req, r_fl, r_st, r_em;
            logic [3:0] r_m;
            logic e_busy, e_ack, e_hold, e_sh, e_ff;
            logic [3:0] e_lane;
            int ackc;
            r_req = ($urandom % 4) == 0;
            r_m   = 4'($urandom);
            r_em  = ($urandom % 3) != 0;
            r_st  = ($urandom % 4) == 0;
            r_fl  = ($urandom % 16) == 0;
            if ((c % 500) >= 100 && (c % 500) < 190) begin
                r_em = 1'b0;
                r_fl = 1'b0;
            end
            cfgReq_i = r_req; cfgLaneMask_i = r_m; pipeEmpty_i = r_em;
            renStall_i = r_st; flush_i = r_fl;

            if (m_act && m_e >= 0 && c > m_e + ST + 2) begin
                m_act = 1'b0;
                m_cur = m_pend;
            end
            ackc   = m_e + ST + 2;
            e_busy = m_act && (c > m_s);
            e_ack  = m_act && (m_e >= 0) && (c == ackc);
            e_hold = e_busy && !e_ack;
            e_sh   = m_act && (m_e >= 0) && (c >= m_e + 2) && (c < ackc);
            e_lane = (m_act && (m_e >= 0) && (c >= m_e + 2)) ? m_pend : m_cur;
            e_ff   = m_act && (m_e < 0) && (c == m_s + DT + 1);

            @(negedge clk);
            chk("rnd_lane", laneActive_o, e_lane);
            chk("rnd_hold", holdInstBuf_o, e_hold);
            chk("rnd_stall", stall_o, r_st | e_sh);
            chk("rnd_ff", forceFlush_o, e_ff);
            chk("rnd_ack", cfgAck_o, e_ack);
            chk("rnd_busy", cfgBusy_o, e_busy);

            if (!m_act) begin
                if (r_req) begin
                    m_act  = 1'b1;
                    m_s    = c;
                    m_e    = -1;
                    m_pend = legal_ref(r_m);
                end
            end else if (m_e < 0 && c > m_s && (r_fl || (r_em && !r_st))) begin
                m_e = c;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
